// File: rtl/gmii_rx_ctrl.sv
// gmii_rx_ctrl: frame-boundary gate for the GMII receive stream plus saturating
// receive statistics with atomic snapshot-and-clear.
module gmii_rx_ctrl #(
    parameter int CNT_WIDTH   = 32,
    parameter int IDLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic                 enable,
    input  logic [7:0]           gmii_rxd_in,
    input  logic                 gmii_rx_dv_in,
    input  logic                 gmii_rx_er_in,
    output logic [7:0]           gmii_rxd_out,
    output logic                 gmii_rx_dv_out,
    output logic                 gmii_rx_er_out,
    input  logic                 rx_axis_tvalid,
    input  logic                 rx_axis_tlast,
    input  logic                 rx_axis_tuser,
    input  logic                 rx_start_packet,
    input  logic                 rx_error_bad_frame,
    input  logic                 rx_error_bad_fcs,
    input  logic                 snap,
    output logic                 active,
    output logic [CNT_WIDTH-1:0] cnt_frames,
    output logic [CNT_WIDTH-1:0] cnt_good,
    output logic [CNT_WIDTH-1:0] cnt_bad_frame,
    output logic [CNT_WIDTH-1:0] cnt_bad_fcs,
    output logic [CNT_WIDTH-1:0] cnt_skipped,
    output logic [CNT_WIDTH-1:0] cnt_bytes
);
    typedef enum logic [1:0] {OFF, WAIT_IDLE, ON, DRAIN} state_t;
    localparam int NC = 6;
    localparam logic [3:0] IDLE_W = 4'(IDLE_CYCLES);

    state_t               state_q, state_d;
    logic [3:0]           idle_q, idle_d;
    logic                 dv_prev_q;
    logic                 skip_ev;
    logic [9:0]           out_q, out_d;
    logic                 active_q, active_d;
    logic [NC-1:0]        ev;
    logic [CNT_WIDTH-1:0] live_q [NC];
    logic [CNT_WIDTH-1:0] live_d [NC];
    logic [CNT_WIDTH-1:0] live_inc [NC];
    logic [CNT_WIDTH-1:0] snap_q [NC];
    logic [CNT_WIDTH-1:0] snap_d [NC];

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        skip_ev = 1'b0;
        case (state_q)
            OFF: begin
                if (enable) begin
                    state_d = WAIT_IDLE;
                    idle_d  = '0;
                    skip_ev = gmii_rx_dv_in;
                end
            end
            WAIT_IDLE: begin
                // a frame already in flight is rejected; count each one once
                idle_d  = gmii_rx_dv_in ? 4'd0 : idle_q + 4'd1;
                skip_ev = gmii_rx_dv_in & ~dv_prev_q;
                if (!enable)
                    state_d = OFF;
                else if (idle_d == IDLE_W)
                    state_d = ON;
            end
            ON:      if (!enable) state_d = gmii_rx_dv_in ? DRAIN : OFF;
            DRAIN:   if (enable) state_d = ON; else if (!gmii_rx_dv_in) state_d = OFF;
            default: state_d = OFF;
        endcase
        out_d    = (state_q == ON || state_q == DRAIN) ? {gmii_rx_dv_in, gmii_rx_er_in, gmii_rxd_in} : '0;
        active_d = (state_d == ON || state_d == DRAIN);
    end

    assign ev = {rx_axis_tvalid, skip_ev, rx_error_bad_fcs, rx_error_bad_frame,
                 rx_axis_tvalid & rx_axis_tlast & ~rx_axis_tuser, rx_start_packet};

    // the snapshot takes the incremented value so a same-cycle event is not lost
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            live_inc[i] = (ev[i] && !(&live_q[i])) ? live_q[i] + CNT_WIDTH'(1) : live_q[i];
            live_d[i]   = snap ? '0 : live_inc[i];
            snap_d[i]   = snap ? live_inc[i] : snap_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OFF;
            idle_q    <= '0;
            dv_prev_q <= 1'b0;
            out_q     <= '0;
            active_q  <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else if (clk_enable) begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            dv_prev_q <= gmii_rx_dv_in;
            out_q     <= out_d;
            active_q  <= active_d;
            for (int i = 0; i < NC; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign {gmii_rx_dv_out, gmii_rx_er_out, gmii_rxd_out} = out_q;
    assign active        = active_q;
    assign cnt_frames    = snap_q[0];
    assign cnt_good      = snap_q[1];
    assign cnt_bad_frame = snap_q[2];
    assign cnt_bad_fcs   = snap_q[3];
    assign cnt_skipped   = snap_q[4];
    assign cnt_bytes     = snap_q[5];
endmodule
